// File: rtl/par_acc_pkg.sv
// Shared helpers and FSM encoding for the parallel-lane accumulator.
package par_acc_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // Popcount width needed for n lanes (all-ones must fit).
    function automatic int cw_of(input int lanes);
        return clog2(lanes) + 1;
    endfunction

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} par_acc_state_t;

endpackage

// File: rtl/par_popcount_pipe.sv
// Popcount of a lane vector via a recursive binary adder tree of 4-input counters,
// with an optional output register for the count and its valid bit.
module parallel_ctr_4in (
    input  logic [3:0] a,
    output logic [2:0] s
);
    assign s = {2'b00, a[0]} + {2'b00, a[1]} + {2'b00, a[2]} + {2'b00, a[3]};
endmodule

module par_popcount_tree
    import par_acc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         bits,
    output logic [cw_of(N)-1:0]  cnt
);
    localparam int H = N / 2;

    if (N == 2) begin : g_pair
        assign cnt = {bits[0] & bits[1], bits[0] ^ bits[1]};
    end else if (N == 4) begin : g_leaf
        parallel_ctr_4in u_leaf (.a(bits), .s(cnt));
    end else begin : g_split
        logic [cw_of(H)-1:0] lo, hi;
        par_popcount_tree #(.N(H)) u_lo (.bits(bits[H-1:0]), .cnt(lo));
        par_popcount_tree #(.N(H)) u_hi (.bits(bits[N-1:H]), .cnt(hi));
        assign cnt = {1'b0, lo} + {1'b0, hi};
    end
endmodule

module par_popcount_pipe
    import par_acc_pkg::*;
#(
    parameter int LANES = 64,
    parameter int PIPE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [LANES-1:0]         data_in,
    output logic [cw_of(LANES)-1:0]  pc,
    output logic                     pc_valid
);
    localparam int CW = cw_of(LANES);

    logic [CW-1:0] pc_c;

    par_popcount_tree #(.N(LANES)) u_tree (.bits(data_in), .cnt(pc_c));

    if (PIPE != 0) begin : g_reg
        logic [CW-1:0] pc_d, pc_q;
        logic          v_d, v_q;

        always_comb begin
            pc_d = pc_c;
            v_d  = in_valid;
            if (clr) begin
                pc_d = '0;
                v_d  = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pc_q <= '0;
                v_q  <= 1'b0;
            end else begin
                pc_q <= pc_d;
                v_q  <= v_d;
            end
        end

        assign pc       = pc_q;
        assign pc_valid = v_q;
    end else begin : g_comb
        assign pc       = pc_c;
        assign pc_valid = in_valid & ~clr;
    end
endmodule

// File: rtl/par_acc_window.sv
// Accumulates lane popcounts into a saturating or wrapping counter and
// optionally reports one result per fixed-length window of valid beats.
module par_acc_window
    import par_acc_pkg::*;
#(
    parameter int LANES = 64,
    parameter int WIDTH = 16,
    parameter int SAT   = 1,
    parameter int PIPE  = 1,
    parameter int WIN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [LANES-1:0] data_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [WIDTH-1:0] countval,
    output logic             overflow,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_count,
    output logic             out_ovf
);
    localparam int CW = cw_of(LANES);
    localparam logic [WIN_W-1:0] WL_ONE = WIN_W'(1);

    logic [CW-1:0]    pc;
    logic             pc_valid;

    par_popcount_pipe #(.LANES(LANES), .PIPE(PIPE)) u_pc (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
        .data_in(data_in), .pc(pc), .pc_valid(pc_valid)
    );

    logic [WIDTH-1:0] acc_d, acc_q, out_count_d, out_count_q;
    logic [WIN_W-1:0] beat_cnt_d, beat_cnt_q, wl_d, wl_q;
    logic             ovf_d, ovf_q, wovf_d, wovf_q;
    logic             out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;
    par_acc_state_t   state_d, state_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_add;
    logic [WIN_W-1:0] wl_eff;
    logic             wovf_now, close;

    always_comb begin
        sum      = {1'b0, acc_q} + (WIDTH + 1)'(pc);
        acc_add  = (SAT != 0 && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        // The window length is captured by the first beat of a window only.
        wl_eff   = (state_q == IDLE) ? win_len : wl_q;
        wovf_now = wovf_q | sum[WIDTH];
        close    = pc_valid && (wl_eff != '0) && (beat_cnt_q == wl_eff - WL_ONE);

        acc_d       = acc_q;
        beat_cnt_d  = beat_cnt_q;
        wl_d        = wl_q;
        ovf_d       = ovf_q;
        wovf_d      = wovf_q;
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (pc_valid) begin
            ovf_d = ovf_q | sum[WIDTH];
            wl_d  = wl_eff;
            if (close) begin
                out_valid_d = 1'b1;
                out_count_d = acc_add;
                out_ovf_d   = wovf_now;
                acc_d       = '0;
                beat_cnt_d  = '0;
                wovf_d      = 1'b0;
                state_d     = IDLE;
            end else begin
                acc_d      = acc_add;
                wovf_d     = wovf_now;
                state_d    = ACCUM;
                // Free-running mode keeps the beat counter parked at zero.
                beat_cnt_d = (wl_eff != '0) ? beat_cnt_q + WL_ONE : '0;
            end
        end

        if (clr) begin
            acc_d       = '0;
            beat_cnt_d  = '0;
            wl_d        = '0;
            ovf_d       = 1'b0;
            wovf_d      = 1'b0;
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_count_d = '0;
            out_ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            wl_q        <= '0;
            ovf_q       <= 1'b0;
            wovf_q      <= 1'b0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            wl_q        <= wl_d;
            ovf_q       <= ovf_d;
            wovf_q      <= wovf_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign countval  = acc_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_par_acc_window.sv
// Directed bench: one 16-bit saturating instance plus 8-bit saturating and
// wrapping instances sharing the same stimulus.
module tb_par_acc_window;
    logic        clk = 1'b0;
    logic        rst, clr, in_valid;
    logic [63:0] data_in;
    logic [9:0]  win_len;

    logic [15:0] cv0, oc0;
    logic [7:0]  cv1, oc1, cv2, oc2;
    logic        ov0, vl0, oo0, ov1, vl1, oo1, ov2, vl2, oo2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    par_acc_window #(.LANES(64), .WIDTH(16), .SAT(1), .PIPE(1), .WIN_W(10)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .data_in(data_in),
        .win_len(win_len), .countval(cv0), .overflow(ov0), .out_valid(vl0),
        .out_count(oc0), .out_ovf(oo0));
    par_acc_window #(.LANES(64), .WIDTH(8), .SAT(1), .PIPE(1), .WIN_W(10)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .data_in(data_in),
        .win_len(win_len), .countval(cv1), .overflow(ov1), .out_valid(vl1),
        .out_count(oc1), .out_ovf(oo1));
    par_acc_window #(.LANES(64), .WIDTH(8), .SAT(0), .PIPE(1), .WIN_W(10)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .data_in(data_in),
        .win_len(win_len), .countval(cv2), .overflow(ov2), .out_valid(vl2),
        .out_count(oc2), .out_ovf(oo2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int n);
        in_valid = 1'b1;
        data_in  = (n >= 64) ? '1 : ((64'(1) << n) - 64'(1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; win_len = '0;
        idle();
        tick(); tick();
        chk("rst_cv", cv0, 0);
        chk("rst_ovf", ov0, 0);
        chk("rst_vld", vl0, 0);
        chk("rst_oc", oc0, 0);
        chk("rst_oo", oo0, 0);
        rst = 1'b1;
        tick();

        // free-running: 4 all-ones beats
        beat(64);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("free_cv", cv0, 32'(64 * i));
            chk("free_vld", vl0, 0);
        end
        idle();
        tick();
        chk("free_cv4", cv0, 256);
        chk("free_vld4", vl0, 0);
        chk("sat8_cv", cv1, 255);
        chk("sat8_ovf", ov1, 1);
        chk("wrap8_cv", cv2, 0);
        chk("wrap8_ovf", ov2, 1);
        chk("w16_ovf", ov0, 0);

        // long run of popcount-5 beats
        beat(5);
        repeat (200) tick();
        idle();
        tick(); tick();
        chk("run_cv16", cv0, 1256);
        chk("run_sat8", cv1, 255);
        chk("run_wrap8", cv2, 232);
        chk("run_ovf8", ov1, 1);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cv", cv0, 0);
        chk("clr_ovf8", ov1, 0);
        chk("clr_cv8", cv2, 0);

        // window of 5 all-ones beats overflows the 8-bit instances
        win_len = 10'd5;
        beat(64);
        repeat (5) tick();
        idle();
        tick();
        chk("wov_vld", vl0, 1);
        chk("wov_oc16", oc0, 320);
        chk("wov_oo16", oo0, 0);
        chk("wov_oc_sat", oc1, 255);
        chk("wov_oo_sat", oo1, 1);
        chk("wov_oc_wrap", oc2, 64);
        chk("wov_oo_wrap", oo2, 1);
        chk("wov_cv", cv0, 0);
        tick();
        chk("wov_pulse1", vl0, 0);

        // win_len=3, pcs 5,7,9; a win_len change mid-window is ignored
        win_len = 10'd3;
        beat(5); tick();
        beat(7); tick();
        beat(9); win_len = 10'd2; tick();
        idle();
        chk("w3_novld", vl0, 0);
        tick();
        chk("w3_vld", vl0, 1);
        chk("w3_oc", oc0, 21);
        chk("w3_oo", oo0, 0);
        chk("w3_cv", cv0, 0);
        chk("w3_sticky8", ov1, 1);
        chk("w3_oo8", oo1, 0);
        tick();
        chk("w3_pulse1", vl0, 0);
        chk("w3_hold", oc0, 21);

        // win_len=2 with bubbles: valid 1,0,0,1
        beat(3); tick();
        idle(); tick();
        tick();
        beat(4); tick();
        idle();
        chk("bub_novld", vl0, 0);
        tick();
        chk("bub_vld", vl0, 1);
        chk("bub_oc", oc0, 7);
        tick();

        // clr with a beat mid-window
        beat(3); tick();
        idle(); tick();
        beat(4); clr = 1'b1; tick();
        clr = 1'b0; idle();
        chk("clrw_cv", cv0, 0);
        chk("clrw_ovf8", ov1, 0);
        tick();
        chk("clrw_novld", vl0, 0);
        chk("clrw_cv2", cv0, 0);
        beat(6); tick();
        beat(2); tick();
        idle();
        chk("clrw_cv3", cv0, 6);
        tick();
        chk("clrw_vld", vl0, 1);
        chk("clrw_oc", oc0, 8);

        // win_len=1: every beat closes a window, back to back
        win_len = 10'd1;
        beat(5); tick();
        beat(6); tick();
        idle();
        chk("w1_vld_a", vl0, 1);
        chk("w1_oc_a", oc0, 5);
        tick();
        chk("w1_vld_b", vl0, 1);
        chk("w1_oc_b", oc0, 6);
        chk("w1_cv", cv0, 0);

        // async reset with a window open
        win_len = 10'd4;
        beat(9); tick();
        idle(); tick();
        chk("pre_rst_cv", cv0, 9);
        rst = 1'b0;
        #1;
        chk("arst_cv", cv0, 0);
        chk("arst_oc", oc0, 0);
        chk("arst_vld", vl0, 0);
        chk("arst_ovf", ov0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
